multi_sel_seq: RTL and testbench
================================

Name: multi_sel_seq

Overview:
- Parametrised successor to the fixed 4-phase sampler/multiplier.
- Accepts one WIDTH-bit sample through a valid/grant handshake, then emits it multiplied by NUM_PHASES programmable constant coefficients, one product per accepted output beat.
- Adds output backpressure, a synchronous flush, and a phase tag on every product.
- Sits between a sample source and a downstream accumulator/filter stage.

Parameters:
- WIDTH, 8: sample width in bits.
- CW, 4: coefficient width in bits, unsigned.
- NUM_PHASES, 4: number of products per sample; legal range 2..8.
- COEFS, 16'h8731: packed coefficients, NUM_PHASES*CW bits, phase 0 in the LSBs. The default gives 1, 3, 7, 8.
- PW, derived: phase-index width = max(1, clog2(NUM_PHASES)).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-low.
- in_valid  input  1  source has a sample on d.
- d  input  WIDTH  sample data.
- input_grant  output  1  block can accept a sample (registered).
- out_ready  input  1  downstream accepts the current product.
- flush  input  1  synchronous abort of the sample in progress.
- out_valid  output  1  out/out_phase hold a valid product (registered).
- out  output  WIDTH+CW  d_reg * COEFS[out_phase], unsigned, never overflows.
- out_phase  output  PW  index of the coefficient used for out.

Behaviour:
- One clock domain. rst is synchronous and active-low: it is sampled only at the rising edge of clk, and rst==0 resets the block.
- Reset values: state=IDLE, input_grant=1, out_valid=0, out=0, out_phase=0, d_reg=0.
- Reset asserted mid-operation discards the sample; outputs take reset values at that edge.
- States: IDLE, RUN.
- IDLE behaviour:
  - input_grant=1, out_valid=0.
  - At an edge with in_valid=1: d_reg<=d, out<=d*COEFS[0], out_phase<=0, out_valid<=1, input_grant<=0, state<=RUN.
  - Latency from capture edge to first valid product is 0 cycles; the product is visible immediately after the capture edge.
- RUN behaviour:
  - out/out_phase stay stable while out_valid=1 and out_ready=0.
  - An edge with out_ready=1 and out_phase<NUM_PHASES-1: out_phase<=out_phase+1, out<=d_reg*COEFS[out_phase+1].
  - An edge with out_ready=1 and out_phase==NUM_PHASES-1: out_valid<=0, input_grant<=1, state<=IDLE.
- in_valid is ignored in RUN; the source must hold the sample until it is granted. No sample is lost or duplicated.
- Throughput: at best one sample per NUM_PHASES+1 cycles, because IDLE always lasts at least 1 cycle.
- flush=1 at any edge (rst high) forces IDLE:
  - out_valid<=0, input_grant<=1, out_phase<=0.
  - out keeps its last value; d_reg is not cleared.
  - flush takes priority over both capture and advance.
  - flush in IDLE has no effect, and in_valid is not captured on that edge.
- Arithmetic: out is computed as a zero-extended unsigned product at full width WIDTH+CW; no truncation or saturation.
- Coefficient 0 is legal and produces out=0 with out_valid=1.

Decomposition:
- Shared package multi_sel_pkg holds:
  - state encoding: IDLE=1'b0, RUN=1'b1;
  - a function that extracts the coefficient for index i from COEFS;
  - the PW computation.
- One sub-module, coef_mul: combinational, WIDTH x CW unsigned multiplier with a coefficient-select mux, parametrised by WIDTH/CW/NUM_PHASES/COEFS. The top level registers its result.

Test Plan:
- Basic, defaults, out_ready=1: d=8'd10 with in_valid -> products 10,30,70,80 on phases 0..3 in consecutive cycles, then 1 IDLE cycle with input_grant=1.
- Max value: d=8'd255 -> 255,765,1785,2040 on a 12-bit out, no wrap.
- Backpressure: out_ready=0 for 3 cycles during phase 1 with d=10 -> out holds 30 and out_phase holds 1; sequence resumes 70,80 with no skip or duplicate.
- Busy input: in_valid=1 continuously with d changing during RUN -> only the granted value is used. Next capture occurs exactly one cycle after phase 3 is accepted, and input_grant is low throughout RUN.
- Flush/reset mid-operation: flush at phase 2 -> next cycle out_valid=0, input_grant=1, out_phase=0. Repeat with rst=0 -> every output at its reset value at that edge, asserted simultaneously with in_valid.
- Reparametrised, WIDTH=4, CW=4, NUM_PHASES=2, COEFS=8'hF5: d=4'd15 -> 75 then 225 on an 8-bit out, out_phase 0 then 1.

Source files
------------

// File: rtl/multi_sel_pkg.sv
// Shared definitions for the multi-phase sample multiplier: state encoding,
// phase-index width and coefficient extraction from the packed COEFS vector.
package multi_sel_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  // Phase-index width, never narrower than one bit.
  function automatic int unsigned calc_pw(int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Coefficient i of a packed vector (phase 0 in the LSBs), zero-extended to 64 bits.
  function automatic logic [63:0] coef_at(logic [63:0] coefs, int unsigned cw, int unsigned i);
    logic [63:0] mask;
    mask = (64'd1 << cw) - 64'd1;
    return (coefs >> (i * cw)) & mask;
  endfunction

endpackage

// File: rtl/coef_mul.sv
// Combinational WIDTH x CW unsigned multiplier with a coefficient-select mux.
module coef_mul
  import multi_sel_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned CW         = 4,
  parameter int unsigned NUM_PHASES = 4,
  parameter logic [NUM_PHASES*CW-1:0] COEFS = 16'h8731,
  localparam int unsigned PW = calc_pw(NUM_PHASES)
) (
  input  logic [WIDTH-1:0]    d_i,
  input  logic [PW-1:0]       sel_i,
  output logic [WIDTH+CW-1:0] prod_o
);

  logic [CW-1:0] coef;

  // Out-of-range selects yield a zero coefficient.
  always_comb begin
    coef = '0;
    for (int unsigned i = 0; i < NUM_PHASES; i++) begin
      if (sel_i == PW'(i)) begin
        coef = CW'(coef_at(64'(COEFS), CW, i));
      end
    end
  end

  assign prod_o = (WIDTH + CW)'(d_i) * (WIDTH + CW)'(coef);

endmodule

// File: rtl/multi_sel_seq.sv
// Captures one sample via valid/grant, then emits NUM_PHASES products with
// programmable coefficients under output backpressure, with synchronous flush.
module multi_sel_seq
  import multi_sel_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned CW         = 4,
  parameter int unsigned NUM_PHASES = 4,
  parameter logic [NUM_PHASES*CW-1:0] COEFS = 16'h8731,
  localparam int unsigned PW = calc_pw(NUM_PHASES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [WIDTH-1:0]    d,
  output logic                input_grant,
  input  logic                out_ready,
  input  logic                flush,
  output logic                out_valid,
  output logic [WIDTH+CW-1:0] out,
  output logic [PW-1:0]       out_phase
);

  localparam logic [PW-1:0] LastPhase = PW'(NUM_PHASES - 1);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    d_reg_q, d_reg_d;
  logic [WIDTH+CW-1:0] out_q, out_d;
  logic [PW-1:0]       phase_q, phase_d;
  logic                valid_q, valid_d;
  logic                grant_q, grant_d;

  logic [WIDTH-1:0]    mul_op;
  logic [PW-1:0]       mul_sel;
  logic [WIDTH+CW-1:0] mul_prod;
  logic                last_phase;

  assign last_phase = (phase_q == LastPhase);

  // One shared multiplier: the incoming sample in IDLE, the held sample in RUN.
  assign mul_op  = (state_q == StIdle) ? d : d_reg_q;
  assign mul_sel = (state_q == StIdle) ? '0 : phase_q + PW'(1);

  coef_mul #(
    .WIDTH     (WIDTH),
    .CW        (CW),
    .NUM_PHASES(NUM_PHASES),
    .COEFS     (COEFS)
  ) u_coef_mul (
    .d_i   (mul_op),
    .sel_i (mul_sel),
    .prod_o(mul_prod)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      d_reg_q <= '0;
      out_q   <= '0;
      phase_q <= '0;
      valid_q <= 1'b0;
      grant_q <= 1'b1;
    end else begin
      state_q <= state_d;
      d_reg_q <= d_reg_d;
      out_q   <= out_d;
      phase_q <= phase_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (!flush && in_valid) state_d = StRun;
      StRun:  if (flush || (out_ready && last_phase)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    d_reg_d = d_reg_q;
    out_d   = out_q;
    phase_d = phase_q;
    valid_d = valid_q;
    grant_d = grant_q;
    unique case (state_q)
      StIdle: begin
        if (!flush && in_valid) begin
          d_reg_d = d;
          out_d   = mul_prod;
          phase_d = '0;
          valid_d = 1'b1;
          grant_d = 1'b0;
        end
      end
      StRun: begin
        if (flush) begin
          // out and d_reg are deliberately left untouched.
          phase_d = '0;
          valid_d = 1'b0;
          grant_d = 1'b1;
        end else if (out_ready) begin
          if (last_phase) begin
            valid_d = 1'b0;
            grant_d = 1'b1;
          end else begin
            phase_d = phase_q + PW'(1);
            out_d   = mul_prod;
          end
        end
      end
      default: ;
    endcase
  end

  assign input_grant = grant_q;
  assign out_valid   = valid_q;
  assign out         = out_q;
  assign out_phase   = phase_q;

endmodule

// File: tb/tb_multi_sel_seq.sv
// Bench for multi_sel_seq: queue-of-products reference model plus directed literal checks.
module tb_multi_sel_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  d;
  logic        input_grant;
  logic        out_ready;
  logic        flush;
  logic        out_valid;
  logic [11:0] dout;
  logic [1:0]  out_phase;

  logic       b_in_valid;
  logic [3:0] b_d;
  logic       b_grant;
  logic       b_valid;
  logic [7:0] b_out;
  logic       b_phase;

  always #5 clk = ~clk;

  multi_sel_seq u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .d          (d),
    .input_grant(input_grant),
    .out_ready  (out_ready),
    .flush      (flush),
    .out_valid  (out_valid),
    .out        (dout),
    .out_phase  (out_phase)
  );

  multi_sel_seq #(
    .WIDTH     (4),
    .CW        (4),
    .NUM_PHASES(2),
    .COEFS     (8'hF5)
  ) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (b_in_valid),
    .d          (b_d),
    .input_grant(b_grant),
    .out_ready  (1'b1),
    .flush      (1'b0),
    .out_valid  (b_valid),
    .out        (b_out),
    .out_phase  (b_phase)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a capture enqueues every product the sample will produce;
  // each accepted beat dequeues one, flush or reset empties the queue.
  typedef struct {
    int val;
    int ph;
  } prod_t;

  int    coef[4] = '{1, 3, 7, 8};
  prod_t m_q[$];
  bit    started    = 0;
  bit    m_zero_out = 1;
  bit    m_phase0   = 1;

  always @(posedge clk) begin
    prod_t p;
    started = 1;
    if (!rst) begin
      m_q.delete();
      m_zero_out = 1;
      m_phase0   = 1;
    end else if (flush) begin
      if (m_q.size() > 0) begin
        m_q.delete();
        m_phase0 = 1;
      end
    end else if (m_q.size() == 0) begin
      if (in_valid) begin
        for (int k = 0; k < 4; k++) begin
          p.val = int'(d) * coef[k];
          p.ph  = k;
          m_q.push_back(p);
        end
        m_zero_out = 0;
        m_phase0   = 0;
      end
    end else if (out_ready) begin
      void'(m_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("out_valid", int'(out_valid), int'(m_q.size() > 0));
      check("input_grant", int'(input_grant), int'(m_q.size() == 0));
      if (m_q.size() > 0) begin
        check("out", int'(dout), m_q[0].val);
        check("out_phase", int'(out_phase), m_q[0].ph);
      end
      if (m_zero_out) check("out_after_reset", int'(dout), 0);
      if (m_phase0) check("phase_zero", int'(out_phase), 0);
    end
  end

  int exp_basic[4] = '{10, 30, 70, 80};
  int exp_max[4]   = '{255, 765, 1785, 2040};

  initial begin
    rst = 1'b0; in_valid = 1'b0; d = '0; out_ready = 1'b1; flush = 1'b0;
    b_in_valid = 1'b0; b_d = '0;
    repeat (2) @(negedge clk);
    check("reset_grant", int'(input_grant), 1);
    check("reset_valid", int'(out_valid), 0);
    check("reset_out", int'(dout), 0);
    rst = 1'b1;
    @(negedge clk);

    // Basic sequence, then max value.
    in_valid = 1'b1; d = 8'd10;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      check("basic_out", int'(dout), exp_basic[k]);
      check("basic_phase", int'(out_phase), k);
    end
    @(negedge clk);
    check("basic_idle_grant", int'(input_grant), 1);
    in_valid = 1'b1; d = 8'd255;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      check("max_out", int'(dout), exp_max[k]);
    end
    @(negedge clk);

    // Backpressure during phase 1.
    in_valid = 1'b1; d = 8'd10;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_hold_out", int'(dout), 30);
      check("bp_hold_phase", int'(out_phase), 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_resume2", int'(dout), 70);
    @(negedge clk);
    check("bp_resume3", int'(dout), 80);
    @(negedge clk);

    // Busy input: in_valid held high with changing data.
    in_valid = 1'b1;
    repeat (14) begin
      d = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (5) @(negedge clk);

    // Flush at phase 2.
    in_valid = 1'b1; d = 8'd10;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_valid", int'(out_valid), 0);
    check("flush_grant", int'(input_grant), 1);
    check("flush_phase", int'(out_phase), 0);
    check("flush_out_kept", int'(dout), 70);
    @(negedge clk);

    // Reset at phase 2, together with in_valid.
    in_valid = 1'b1; d = 8'd10;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; in_valid = 1'b1; d = 8'd99;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    check("rst_valid", int'(out_valid), 0);
    check("rst_grant", int'(input_grant), 1);
    check("rst_out", int'(dout), 0);
    check("rst_phase", int'(out_phase), 0);
    @(negedge clk);

    // Reparametrised instance: coefficients 5 and 15.
    b_in_valid = 1'b1; b_d = 4'd15;
    @(negedge clk);
    b_in_valid = 1'b0;
    check("b_out0", int'(b_out), 75);
    check("b_phase0", int'(b_phase), 0);
    check("b_valid0", int'(b_valid), 1);
    @(negedge clk);
    check("b_out1", int'(b_out), 225);
    check("b_phase1", int'(b_phase), 1);
    @(negedge clk);
    check("b_done", int'(b_valid), 0);

    // Randomised traffic against the model.
    repeat (3000) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      d         = 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 99) != 0);
      @(negedge clk);
    end
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
